// File: rtl/mux_rr_stream_nbit.sv
// Registered N-channel round-robin stream multiplexer with valid/ready handshakes.
// Optional saturating accepted-word counter on port grant_cnt when RR_MUX_GRANT_CNT_EN is defined.
module mux_rr_stream_nbit #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_sel,
  output logic              out_valid,
  input  logic              out_ready
`ifdef RR_MUX_GRANT_CNT_EN
  ,
  output logic [15:0]       grant_cnt
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [SELW-1:0] r_ptr;
  logic [W-1:0]    r_outData;
  logic [SELW-1:0] r_outSel;

  logic [W-1:0]    w_chData [N];
  logic [SELW:0]   w_cand;
  logic [SELW-1:0] w_grantIdx;
  logic            w_anyValid;
  logic            w_slotFree;
  logic            w_take;
  logic [W-1:0]    w_grantData;
  logic [N-1:0]    w_inReady;

  // Scan channels starting at the pointer, wrapping without a modulo so N need not be a power of two.
  always_comb begin
    w_cand     = '0;
    w_grantIdx = '0;
    w_anyValid = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_chData[k] = in_data[k*W +: W];
    end
    for (int i = 0; i < N; i++) begin
      w_cand = {1'b0, r_ptr} + (SELW+1)'(i);
      if (w_cand >= (SELW+1)'(N)) begin
        w_cand = w_cand - (SELW+1)'(N);
      end
      if (!w_anyValid && in_valid[w_cand[SELW-1:0]]) begin
        w_anyValid = 1'b1;
        w_grantIdx = w_cand[SELW-1:0];
      end
    end
  end

  always_comb begin
    w_slotFree  = (r_state == EMPTY) | out_ready;
    w_take      = w_anyValid & w_slotFree & !reset;
    w_grantData = w_chData[w_grantIdx];
    w_inReady   = '0;
    if (w_take) begin
      w_inReady[w_grantIdx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      EMPTY:   if (w_take) w_nextState = FULL;
      FULL:    if (out_ready) w_nextState = w_take ? FULL : EMPTY;
      default: w_nextState = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (r_state == FULL);
    in_ready  = w_inReady;
    out_data  = r_outData;
    out_sel   = r_outSel;
  end

  // Data and selector persist through a drain; only a transfer reloads them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outData <= '0;
      r_outSel  <= '0;
      r_ptr     <= '0;
    end else if (w_take) begin
      r_outData <= w_grantData;
      r_outSel  <= w_grantIdx;
      r_ptr     <= (w_grantIdx == SELW'(N-1)) ? '0 : w_grantIdx + SELW'(1);
    end
  end

`ifdef RR_MUX_GRANT_CNT_EN
  logic [15:0] r_grantCnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_grantCnt <= '0;
    end else if (out_valid && out_ready && r_grantCnt != 16'hFFFF) begin
      r_grantCnt <= r_grantCnt + 16'd1;
    end
  end

  assign grant_cnt = r_grantCnt;
`endif

endmodule

// File: tb/tb_mux_rr_stream_nbit.sv
// Directed self-checking bench for mux_rr_stream_nbit with N=4, W=8.
// Also checks grant_cnt when RR_MUX_GRANT_CNT_EN is defined.
module tb_mux_rr_stream_nbit;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_valid;
  logic         out_ready;
`ifdef RR_MUX_GRANT_CNT_EN
  logic [15:0]  grant_cnt;
`endif

  int errCount   = 0;
  int checkCount = 0;

  mux_rr_stream_nbit #(.N(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef RR_MUX_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, need finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [N-1:0] valid, input logic rdy);
    reset     = rst;
    in_valid  = valid;
    out_ready = rdy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkWord(input string tag, input logic [7:0] expData, input logic [1:0] expSel);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_data"}, 32'(out_data), 32'(expData));
    checkOutput({tag, "_sel"}, 32'(out_sel), 32'(expSel));
  endtask

  initial begin
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // Reset held for two cycles with every channel requesting.
    applyStimulus(1'b1, 4'b1111, 1'b1);
    checkOutput("rst_in_ready_comb", 32'(in_ready), 32'h0);
    step();
    step();
    checkOutput("rst_in_ready", 32'(in_ready), 32'h0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'h00);
    checkOutput("rst_out_sel", 32'(out_sel), 32'd0);
`ifdef RR_MUX_GRANT_CNT_EN
    checkOutput("rst_grant_cnt", 32'(grant_cnt), 32'd0);
`endif

    // All channels valid: rotate A0,A1,A2,A3,A0 back to back.
    applyStimulus(1'b0, 4'b1111, 1'b1);
    for (int j = 0; j < 5; j++) begin
      checkOutput($sformatf("rr_in_ready_%0d", j), 32'(in_ready), 32'(4'b0001 << (j % 4)));
      step();
      checkWord($sformatf("rr_word_%0d", j), 8'hA0 + 8'(j % 4), 2'(j % 4));
    end
    step();
    checkWord("rr_word_5", 8'hA1, 2'd1);

    // Stall for three cycles while every channel is valid.
    applyStimulus(1'b0, 4'b1111, 1'b0);
    for (int j = 0; j < 3; j++) begin
      checkOutput($sformatf("stall_in_ready_%0d", j), 32'(in_ready), 32'h0);
      step();
      checkWord($sformatf("stall_word_%0d", j), 8'hA1, 2'd1);
    end
    applyStimulus(1'b0, 4'b1111, 1'b1);
    checkOutput("unstall_in_ready", 32'(in_ready), 32'b0100);
    step();
    checkWord("unstall_word", 8'hA2, 2'd2);

    // Pointer at 3 with only ch0/ch1 valid: wrap to ch0, then ch1, then drain.
    applyStimulus(1'b0, 4'b0011, 1'b1);
    checkOutput("wrap_in_ready_0", 32'(in_ready), 32'b0001);
    step();
    checkWord("wrap_word_0", 8'hA0, 2'd0);
    checkOutput("wrap_in_ready_1", 32'(in_ready), 32'b0010);
    step();
    checkWord("wrap_word_1", 8'hA1, 2'd1);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("drain_in_ready", 32'(in_ready), 32'h0);
    step();
    checkOutput("drain_out_valid", 32'(out_valid), 32'd0);
    checkOutput("drain_out_data", 32'(out_data), 32'hA1);
    checkOutput("drain_out_sel", 32'(out_sel), 32'd1);

    // out_ready while EMPTY does not create a word.
    step();
    checkOutput("empty_out_valid", 32'(out_valid), 32'd0);

    // Only ch2 valid: granted every cycle regardless of pointer position.
    in_data = {8'h00, 8'h5C, 8'h00, 8'h00};
    applyStimulus(1'b0, 4'b0100, 1'b1);
    for (int j = 0; j < 3; j++) begin
      checkOutput($sformatf("solo_in_ready_%0d", j), 32'(in_ready), 32'b0100);
      step();
      checkWord($sformatf("solo_word_%0d", j), 8'h5C, 2'd2);
    end

    // Reset pulse while FULL discards the held word and clears the pointer.
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    applyStimulus(1'b1, 4'b1111, 1'b1);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'h0);
    step();
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_data", 32'(out_data), 32'h00);
`ifdef RR_MUX_GRANT_CNT_EN
    checkOutput("midrst_grant_cnt", 32'(grant_cnt), 32'd0);
`endif
    applyStimulus(1'b0, 4'b1111, 1'b1);
    step();
    checkWord("post_word_0", 8'hA0, 2'd0);
    step();
    checkWord("post_word_1", 8'hA1, 2'd1);
    step();
    checkWord("post_word_2", 8'hA2, 2'd2);
`ifdef RR_MUX_GRANT_CNT_EN
    checkOutput("post_grant_cnt", 32'(grant_cnt), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
